// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one pipelined FPU multiplier
// among NUM_REQ FFT butterfly requesters, with a flush/drain sequence used
// between FFT frames.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/a/b         per-requester operand pairs (slice r = requester r)
//   o_req_ready             one-hot or zero grant (combinational)
//   o_mul_valid/a/b         registered multiplier launch
//   i_mul_result            multiplier output, MUL_LATENCY cycles after launch
//   o_res_valid/o_res_data  one-hot result pulse and shared result data
//   i_flush, o_flush_done   drain request and completion pulse
//   o_busy                  at least one operation in flight
//   o_grant_cnt             per-requester saturating grant counters
//                           (only when MUL_SCHED_STATS_EN is defined)
module mul_share_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SIZE_DATA   = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_mul_valid,
  output logic [SIZE_DATA-1:0]           o_mul_a,
  output logic [SIZE_DATA-1:0]           o_mul_b,
  input  logic [SIZE_DATA-1:0]           i_mul_result,
  output logic [NUM_REQ-1:0]             o_res_valid,
  output logic [SIZE_DATA-1:0]           o_res_data,
  input  logic                           i_flush,
  output logic                           o_flush_done,
  output logic                           o_busy
`ifdef MUL_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          o_grant_cnt
`endif
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 3);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t               state;
  logic [TAG_W-1:0]     ptr;
  logic                 gnt_found;
  logic [TAG_W-1:0]     gnt_idx;
  int unsigned          cand;
  logic [SIZE_DATA-1:0] sel_a;
  logic [SIZE_DATA-1:0] sel_b;
  logic                 hs;
  logic [TAG_W-1:0]     mul_tag;
  logic                 pipe_vld [MUL_LATENCY];
  logic [TAG_W-1:0]     pipe_tag [MUL_LATENCY];
  logic [CNT_W-1:0]     inflight;

  // Round-robin search from ptr upward, plus operand mux for the winner
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!gnt_found && i_req_valid[TAG_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAG_W'(cand);
      end
    end
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (gnt_idx == TAG_W'(r)) begin
        sel_a = i_req_a[r*SIZE_DATA +: SIZE_DATA];
        sel_b = i_req_b[r*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  // Grants only in RUN without a pending flush; held at zero during reset
  assign o_req_ready = (i_rst_n && (state == ST_RUN) && !i_flush && gnt_found)
                       ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign hs     = |(i_req_valid & o_req_ready);
  assign o_busy = (inflight != '0);

  // FSM, arbiter pointer, launch, tag pipe, result return and in-flight count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_RUN;
      ptr          <= '0;
      o_mul_valid  <= 1'b0;
      o_mul_a      <= '0;
      o_mul_b      <= '0;
      mul_tag      <= '0;
      o_res_valid  <= '0;
      o_res_data   <= '0;
      o_flush_done <= 1'b0;
      inflight     <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      o_flush_done <= 1'b0;
      case (state)
        ST_RUN:   if (i_flush) state <= ST_DRAIN;
        ST_DRAIN: if (inflight == '0) begin
                    state        <= ST_DONE;
                    o_flush_done <= 1'b1;
                  end
        ST_DONE:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase

      if (state == ST_DONE) begin
        ptr <= '0;
      end else if (hs) begin
        ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end

      o_mul_valid <= hs;
      if (hs) begin
        o_mul_a <= sel_a;
        o_mul_b <= sel_b;
        mul_tag <= gnt_idx;
      end

      // Tag enters alongside o_mul_valid so the last stage lines up with i_mul_result
      pipe_vld[0] <= o_mul_valid;
      pipe_tag[0] <= mul_tag;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      if (pipe_vld[MUL_LATENCY-1]) begin
        o_res_valid <= NUM_REQ'(1) << pipe_tag[MUL_LATENCY-1];
        o_res_data  <= i_mul_result;
      end else begin
        o_res_valid <= '0;
      end

      case ({hs, |o_res_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef MUL_SCHED_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters, cleared at the end of each drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) grant_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (state == ST_DONE) begin
          grant_cnt[r] <= '0;
        end else if (hs && (gnt_idx == TAG_W'(r)) && (grant_cnt[r] != 16'hFFFF)) begin
          grant_cnt[r] <= grant_cnt[r] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) o_grant_cnt[r*16 +: 16] = grant_cnt[r];
  end
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched (NUM_REQ=4, MUL_LATENCY=3) with a
// behavioural multiplier pipeline and a result monitor.
module tb_mul_share_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     i_req_valid;
  logic [NR*DW-1:0]  i_req_a;
  logic [NR*DW-1:0]  i_req_b;
  logic [NR-1:0]     o_req_ready;
  logic              o_mul_valid;
  logic [DW-1:0]     o_mul_a;
  logic [DW-1:0]     o_mul_b;
  logic [DW-1:0]     i_mul_result;
  logic [NR-1:0]     o_res_valid;
  logic [DW-1:0]     o_res_data;
  logic              i_flush;
  logic              o_flush_done;
  logic              o_busy;
`ifdef MUL_SCHED_STATS_EN
  logic [NR*16-1:0]  o_grant_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int peak     = 0;

  logic [NR-1:0] obs_v [$];
  logic [DW-1:0] obs_d [$];
  int            obs_c [$];

  always #5 clk = ~clk;

  mul_share_sched #(.NUM_REQ(NR), .SIZE_DATA(DW), .MUL_LATENCY(L)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_req_ready  (o_req_ready),
    .o_mul_valid  (o_mul_valid),
    .o_mul_a      (o_mul_a),
    .o_mul_b      (o_mul_b),
    .i_mul_result (i_mul_result),
    .o_res_valid  (o_res_valid),
    .o_res_data   (o_res_data),
    .i_flush      (i_flush),
    .o_flush_done (o_flush_done),
    .o_busy       (o_busy)
`ifdef MUL_SCHED_STATS_EN
    ,
    .o_grant_cnt  (o_grant_cnt)
`endif
  );

  // Stand-in multiplier: exact for 2.0*3.0, otherwise a tag-revealing sum
  function automatic logic [DW-1:0] mul_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a + b;
  endfunction

  logic [DW-1:0] mdl [L];
  always @(posedge clk) begin
    mdl[0] <= o_mul_valid ? mul_model(o_mul_a, o_mul_b) : '0;
    for (int i = 1; i < L; i++) mdl[i] <= mdl[i-1];
  end
  assign i_mul_result = mdl[L-1];

  // Result monitor and peak in-flight tracker
  always @(negedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (rst_n && o_res_valid != '0) begin
      obs_v.push_back(o_res_valid);
      obs_d.push_back(o_res_data);
      obs_c.push_back(cyc_cnt);
    end
    if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int step);
    for (int r = 0; r < NR; r++) begin
      i_req_a[r*DW +: DW] = (32'(step) << 8) | 32'(r);
      i_req_b[r*DW +: DW] = 32'h0001_0000;
    end
  endtask

  task automatic clear_obs();
    obs_v.delete();
    obs_d.delete();
    obs_c.delete();
  endtask

  initial begin
    logic [NR-1:0] exp_v [$];
    logic [DW-1:0] exp_d [$];
    logic [NR-1:0] tags3 [3];
    bit done;
    int zero_cnt;

    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    i_flush     = 1'b0;

    // Reset state
    repeat (2) cyc();
    check("rst_ready", 64'(o_req_ready), 64'h0);
    check("rst_mul_valid", 64'(o_mul_valid), 64'h0);
    check("rst_mul_a", 64'(o_mul_a), 64'h0);
    check("rst_mul_b", 64'(o_mul_b), 64'h0);
    check("rst_res_valid", 64'(o_res_valid), 64'h0);
    check("rst_res_data", 64'(o_res_data), 64'h0);
    check("rst_flush_done", 64'(o_flush_done), 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    rst_n = 1'b1;
    cyc();

    // Single requester r2: 2.0 * 3.0
    i_req_a[2*DW +: DW] = 32'h4000_0000;
    i_req_b[2*DW +: DW] = 32'h4040_0000;
    i_req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(o_req_ready), 64'h4);
    cyc();
    i_req_valid = '0;
    check("single_mul_valid", 64'(o_mul_valid), 64'h1);
    check("single_mul_a", 64'(o_mul_a), 64'h4000_0000);
    check("single_mul_b", 64'(o_mul_b), 64'h4040_0000);
    check("single_busy", 64'(o_busy), 64'h1);
    for (int i = 0; i < L; i++) begin
      cyc();
      check("single_res_early", 64'(o_res_valid), 64'h0);
      check("single_mul_a_hold", 64'(o_mul_a), 64'h4000_0000);
    end
    check("single_mul_valid_low", 64'(o_mul_valid), 64'h0);
    cyc();
    check("single_res_valid", 64'(o_res_valid), 64'h4);
    check("single_res_data", 64'(o_res_data), 64'h40C0_0000);
    cyc();
    check("single_res_pulse", 64'(o_res_valid), 64'h0);
    check("single_res_hold", 64'(o_res_data), 64'h40C0_0000);
    check("single_idle", 64'(o_busy), 64'h0);

    // Idle flush: no grant alongside i_flush, done two cycles later, ptr back to 0
    set_ops(0);
    i_req_valid = 4'b1111;
    i_flush = 1'b1;
    #1;
    check("flush_same_cycle_ready", 64'(o_req_ready), 64'h0);
    cyc();
    i_flush = 1'b0;
    #1;
    check("idle_drain_ready", 64'(o_req_ready), 64'h0);
    check("idle_drain_done", 64'(o_flush_done), 64'h0);
    cyc();
    check("idle_done_pulse", 64'(o_flush_done), 64'h1);
    check("idle_done_ready", 64'(o_req_ready), 64'h0);
    cyc();
    check("idle_done_clear", 64'(o_flush_done), 64'h0);

    // Continuous 8-cycle burst from all four requesters
    clear_obs();
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      set_ops(i);
      #1;
      check("burst_grant", 64'(o_req_ready), 64'(4'b0001 << (i % 4)));
      exp_v.push_back(4'b0001 << (i % 4));
      exp_d.push_back(((32'(i) << 8) | 32'(i % 4)) + 32'h0001_0000);
      cyc();
    end
    i_req_valid = '0;
    repeat (L + 3) cyc();
    check("burst_count", 64'(obs_v.size()), 64'd8);
    if (obs_v.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("burst_tag", 64'(obs_v[i]), 64'(exp_v[i]));
        check("burst_data", 64'(obs_d[i]), 64'(exp_d[i]));
        if (i > 0) check("burst_b2b", 64'(obs_c[i] - obs_c[i-1]), 64'd1);
      end
    end
    check("burst_peak_inflight", 64'(peak), 64'(L + 2));
    check("burst_idle", 64'(o_busy), 64'h0);

    // Round-robin skip: grant r1 (ptr->2), then r1+r3 valid
    clear_obs();
    i_req_valid = 4'b0010;
    #1;
    check("rr_r1_alone", 64'(o_req_ready), 64'h2);
    cyc();
    i_req_valid = 4'b1010;
    #1;
    check("rr_r3_first", 64'(o_req_ready), 64'h8);
    cyc();
    check("rr_r1_next", 64'(o_req_ready), 64'h2);
    cyc();
    i_req_valid = '0;
    repeat (L + 3) cyc();
    tags3 = '{4'b0010, 4'b1000, 4'b0010};
    check("rr_count", 64'(obs_v.size()), 64'd3);
    if (obs_v.size() == 3)
      for (int i = 0; i < 3; i++) check("rr_tag", 64'(obs_v[i]), 64'(tags3[i]));

    // Flush with three operations in flight (ptr=2: grants r2, r3, r0)
    clear_obs();
    set_ops(5);
    i_req_valid = 4'b1111;
    repeat (3) cyc();
    i_flush = 1'b1;
    #1;
    check("drain_flush_ready", 64'(o_req_ready), 64'h0);
    check("drain_busy", 64'(o_busy), 64'h1);
    cyc();
    i_flush = 1'b0;
    done = 1'b0;
    zero_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      check("drain_no_grant", 64'(o_req_ready), 64'h0);
      if (o_flush_done) begin
        done = 1'b1;
        break;
      end
      if (!o_busy) zero_cnt++;
      cyc();
    end
    check("drain_done_seen", 64'(done), 64'h1);
    check("drain_done_after_zero", 64'(zero_cnt), 64'd1);
    tags3 = '{4'b0100, 4'b1000, 4'b0001};
    check("drain_count", 64'(obs_v.size()), 64'd3);
    if (obs_v.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("drain_tag", 64'(obs_v[i]), 64'(tags3[i]));
        check("drain_data", 64'(obs_d[i]),
              64'(((32'd5 << 8) | 32'((i + 2) % 4)) + 32'h0001_0000));
      end
    end
    cyc();
    check("post_flush_done_clear", 64'(o_flush_done), 64'h0);
    check("post_flush_r0", 64'(o_req_ready), 64'h1);

    // Reset mid-burst drops in-flight operations
    repeat (3) cyc();
    clear_obs();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(o_req_ready), 64'h0);
    check("midrst_mul_valid", 64'(o_mul_valid), 64'h0);
    check("midrst_mul_a", 64'(o_mul_a), 64'h0);
    check("midrst_mul_b", 64'(o_mul_b), 64'h0);
    check("midrst_res_valid", 64'(o_res_valid), 64'h0);
    check("midrst_res_data", 64'(o_res_data), 64'h0);
    check("midrst_flush_done", 64'(o_flush_done), 64'h0);
    check("midrst_busy", 64'(o_busy), 64'h0);
    i_req_valid = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (L + 4) cyc();
    check("midrst_no_stale", 64'(obs_v.size()), 64'd0);
    check("midrst_idle", 64'(o_busy), 64'h0);
    check("midrst_data_zero", 64'(o_res_data), 64'h0);

`ifdef MUL_SCHED_STATS_EN
    // Grant counter saturation
    i_req_valid = 4'b0001;
    repeat (70000) cyc();
    i_req_valid = '0;
    check("stats_r0_sat", 64'(o_grant_cnt[15:0]), 64'hFFFF);
    check("stats_r1_zero", 64'(o_grant_cnt[31:16]), 64'h0);
    repeat (L + 3) cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
